// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the fixed-latency data-memory responder.
// States, default timing/geometry and the data word width live here.
package dmem_responder_pkg;
  localparam int WORD_W          = 32;
  localparam int DEFAULT_LATENCY = 3;
  localparam int DEFAULT_DEPTH   = 32;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one index/data read port.
// The read is combinational so a load can be captured on the same edge that completes it.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);
  logic [WORD_W-1:0] mem [DEPTH];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];
endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency load/store responder for a CPU MEM stage: accepts one request,
// waits LATENCY cycles, then pulses ready_o with data and an error flag.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH   = DEFAULT_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [WORD_W-1:0] Address_i,
  input  logic [WORD_W-1:0] Writedata_i,
  output logic [WORD_W-1:0] Readdata_o,
  output logic              ready_o,
  output logic              stall_o,
  output logic              err_o
);
  localparam int                IDX_W      = $clog2(DEPTH);
  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(4 * DEPTH);
  localparam logic [CNT_W-1:0]  CNT_INIT   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               is_read_reg, is_write_reg, req_err_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic [WORD_W-1:0]  wdata_reg;
  logic               ready_reg, err_out_reg;
  logic [WORD_W-1:0]  rdata_reg;

  logic               req, in_err, accept, enter_resp;
  logic [IDX_W-1:0]   in_idx;
  logic               cur_read, cur_write, cur_err;
  logic [IDX_W-1:0]   cur_idx;
  logic [WORD_W-1:0]  cur_wdata;
  logic               mem_we;
  logic [WORD_W-1:0]  mem_rdata;

  assign req     = MemRead_i | MemWrite_i;
  assign in_idx  = Address_i[IDX_W+1:2];
  assign in_err  = (Address_i[1:0] != 2'b00) || (Address_i >= ADDR_LIMIT) ||
                   (MemRead_i && MemWrite_i);
  assign stall_o = req & ~ready_o;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          accept   = 1'b1;
          cnt_next = CNT_INIT;
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // With LATENCY=1 completion happens on the acceptance edge, so live inputs are used.
  always_comb begin
    if (state_reg == IDLE) begin
      cur_read  = MemRead_i;
      cur_write = MemWrite_i;
      cur_err   = in_err;
      cur_idx   = in_idx;
      cur_wdata = Writedata_i;
    end else begin
      cur_read  = is_read_reg;
      cur_write = is_write_reg;
      cur_err   = req_err_reg;
      cur_idx   = idx_reg;
      cur_wdata = wdata_reg;
    end
  end

  assign mem_we = enter_resp & cur_write & ~cur_err & ~rst_i;

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .wr_en   (mem_we),
    .wr_idx  (cur_idx),
    .wr_data (cur_wdata),
    .rd_idx  (cur_idx),
    .rd_data (mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      is_read_reg  <= 1'b0;
      is_write_reg <= 1'b0;
      req_err_reg  <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      ready_reg    <= 1'b0;
      err_out_reg  <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      ready_reg   <= enter_resp;
      err_out_reg <= enter_resp & cur_err;
      if (accept) begin
        is_read_reg  <= MemRead_i;
        is_write_reg <= MemWrite_i;
        req_err_reg  <= in_err;
        idx_reg      <= in_idx;
        wdata_reg    <= Writedata_i;
      end
      // Stores leave the load data untouched; any error forces it to zero.
      if (enter_resp) begin
        if (cur_err) begin
          rdata_reg <= '0;
        end else if (cur_read) begin
          rdata_reg <= mem_rdata;
        end
      end
    end
  end

  assign Readdata_o = rdata_reg;
  assign ready_o    = ready_reg;
  assign err_o      = err_out_reg;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: a LATENCY=3 instance for the main scenarios and a
// LATENCY=1 instance for back-to-back completion spacing.
module tb_dmem_responder;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;

  logic        rd3 = 1'b0, wr3 = 1'b0;
  logic [31:0] addr3 = '0, wdata3 = '0;
  logic [31:0] rdata3;
  logic        ready3, stall3, err3;

  logic        rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        ready1, stall1, err1;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  dmem_responder #(.LATENCY(3), .DEPTH(32)) u_dut3 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (rd3),
    .MemWrite_i  (wr3),
    .Address_i   (addr3),
    .Writedata_i (wdata3),
    .Readdata_o  (rdata3),
    .ready_o     (ready3),
    .stall_o     (stall3),
    .err_o       (err3)
  );

  dmem_responder #(.LATENCY(1), .DEPTH(32)) u_dut1 (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .MemRead_i   (rd1),
    .MemWrite_i  (wr1),
    .Address_i   (addr1),
    .Writedata_i (wdata1),
    .Readdata_o  (rdata1),
    .ready_o     (ready1),
    .stall_o     (stall1),
    .err_o       (err1)
  );

  // Runs one transaction on the LATENCY=3 instance, scrambling address/data after
  // acceptance. lat = edges from drive to ready (acceptance edge counts as 1), -1 on timeout.
  task automatic txn3(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, output int lat, output logic err,
                      output logic [31:0] rdata, output int stall_cycles,
                      output logic stall_at_ready);
    lat = -1; err = 1'bx; rdata = 'x; stall_cycles = 0; stall_at_ready = 1'bx;
    @(posedge clk_i); #1;
    rd3 = rd; wr3 = wr; addr3 = addr; wdata3 = wdata;
    #1;
    if (stall3) stall_cycles++;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk_i); #1;
      if (ready3) begin
        lat = c; err = err3; rdata = rdata3; stall_at_ready = stall3;
        break;
      end
      if (stall3) stall_cycles++;
      addr3  = addr ^ 32'h0000_0004;
      wdata3 = ~wdata;
    end
    rd3 = 1'b0; wr3 = 1'b0; addr3 = '0; wdata3 = '0;
    $display("txn rd=%0b wr=%0b addr=%08h wdata=%08h -> lat=%0d err=%0b rdata=%08h stall_cycles=%0d",
             rd, wr, addr, wdata, lat, err, rdata, stall_cycles);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; rd3 = 1'b1; rd1 = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if (ready3 !== 1'b0 || err3 !== 1'b0 || rdata3 !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b err=%b rdata=%08h, required 0/0/00000000", ready3, err3, rdata3);
    end
    checks++;
    if (stall3 !== 1'b1 || stall1 !== 1'b1) begin
      failures++;
      $display("FAIL reset_stall_req: stall3=%b stall1=%b, required 1/1", stall3, stall1);
    end
    rd3 = 1'b0; rd1 = 1'b0;
    #1;
    checks++;
    if (stall3 !== 1'b0 || ready1 !== 1'b0 || rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL reset_idle: stall3=%b ready1=%b rdata1=%08h, required 0/0/00000000", stall3, ready1, rdata1);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    $display("reset done");
  endtask

  task automatic test_write();
    int lat, sc; logic e, sr; logic [31:0] d;
    txn3(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, e, d, sc, sr);
    checks++;
    if (lat !== 3) begin failures++; $display("FAIL write_latency: got %0d, required 3", lat); end
    checks++;
    if (e !== 1'b0) begin failures++; $display("FAIL write_err: got %b, required 0", e); end
    checks++;
    if (sc !== 3 || sr !== 1'b0) begin
      failures++; $display("FAIL write_stall: cycles=%0d at_ready=%b, required 3/0", sc, sr);
    end
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL write_keeps_rdata: got %08h, required 00000000", d); end
  endtask

  task automatic test_read_hold();
    int lat, sc; logic e, sr; logic [31:0] d;
    txn3(1'b1, 1'b0, 32'h10, 32'h0, lat, e, d, sc, sr);
    checks++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL read_10: lat=%0d err=%b data=%08h, required 3/0/deadbeef", lat, e, d);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      checks++;
      if (rdata3 !== 32'hDEAD_BEEF || ready3 !== 1'b0) begin
        failures++;
        $display("FAIL read_hold[%0d]: data=%08h ready=%b, required deadbeef/0", i, rdata3, ready3);
      end
    end
  endtask

  task automatic test_errors();
    int lat, sc; logic e, sr; logic [31:0] d;
    txn3(1'b1, 1'b0, 32'h12, 32'h0, lat, e, d, sc, sr);
    checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin
      failures++; $display("FAIL misaligned: lat=%0d err=%b data=%08h, required 3/1/00000000", lat, e, d);
    end
    @(posedge clk_i); #1;
    checks++;
    if (err3 !== 1'b0) begin failures++; $display("FAIL err_clears: got %b, required 0", err3); end
    txn3(1'b1, 1'b0, 32'h80, 32'h0, lat, e, d, sc, sr);
    checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin
      failures++; $display("FAIL out_of_range: lat=%0d err=%b data=%08h, required 3/1/00000000", lat, e, d);
    end
    // 0x90 aliases word 4 (0x10) if the range check were missing.
    txn3(1'b0, 1'b1, 32'h90, 32'h0000_0000, lat, e, d, sc, sr);
    checks++;
    if (lat !== 3 || e !== 1'b1) begin
      failures++; $display("FAIL oor_write: lat=%0d err=%b, required 3/1", lat, e);
    end
    txn3(1'b1, 1'b0, 32'h10, 32'h0, lat, e, d, sc, sr);
    checks++;
    if (e !== 1'b0 || d !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL storage_intact: err=%b data=%08h, required 0/deadbeef", e, d);
    end
  endtask

  task automatic test_both_high();
    int lat, sc; logic e, sr; logic [31:0] d;
    txn3(1'b0, 1'b1, 32'h08, 32'h0BAD_F00D, lat, e, d, sc, sr);
    checks++;
    if (e !== 1'b0 || d !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL store_keeps_rdata: err=%b data=%08h, required 0/deadbeef", e, d);
    end
    txn3(1'b1, 1'b1, 32'h08, 32'hFFFF_FFFF, lat, e, d, sc, sr);
    checks++;
    if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin
      failures++; $display("FAIL both_high: lat=%0d err=%b data=%08h, required 3/1/00000000", lat, e, d);
    end
    txn3(1'b1, 1'b0, 32'h08, 32'h0, lat, e, d, sc, sr);
    checks++;
    if (e !== 1'b0 || d !== 32'h0BAD_F00D) begin
      failures++; $display("FAIL both_high_storage: err=%b data=%08h, required 0/0badf00d", e, d);
    end
  endtask

  task automatic test_reset_abort();
    int lat, sc; logic e, sr; logic [31:0] d;
    int pulses;
    txn3(1'b0, 1'b1, 32'h04, 32'h5555_AAAA, lat, e, d, sc, sr);
    @(posedge clk_i); #1;
    wr3 = 1'b1; addr3 = 32'h04; wdata3 = 32'h0000_1234;
    pulses = 0;
    @(posedge clk_i); #1;            // first WAIT cycle
    if (ready3) pulses++;
    @(posedge clk_i); #1;            // second WAIT cycle
    if (ready3) pulses++;
    rst_i = 1'b1;
    #1;
    checks++;
    if (stall3 !== 1'b1) begin failures++; $display("FAIL abort_stall: got %b, required 1", stall3); end
    @(posedge clk_i); #1;
    if (ready3) pulses++;
    rst_i = 1'b0; wr3 = 1'b0; addr3 = '0; wdata3 = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      if (ready3) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL abort_no_ready: pulses=%0d, required 0", pulses); end
    $display("aborted write 0x04 pulses=%0d", pulses);
    txn3(1'b1, 1'b0, 32'h04, 32'h0, lat, e, d, sc, sr);
    checks++;
    if (lat !== 3 || e !== 1'b0 || d !== 32'h5555_AAAA) begin
      failures++; $display("FAIL abort_storage: lat=%0d err=%b data=%08h, required 3/0/5555aaaa", lat, e, d);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ready_seen;
    logic [31:0] d;
    logic        e, st2;
    ready_seen = '0; d = 'x; e = 1'bx; st2 = 1'bx;
    @(posedge clk_i); #1;
    wr1 = 1'b1; rd1 = 1'b0; addr1 = 32'h04; wdata1 = 32'h0000_00A5;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk_i); #1;
      ready_seen[c-1] = ready1;
      if (c == 1) begin
        wr1 = 1'b0; rd1 = 1'b1; wdata1 = 32'hFFFF_FFFF;
      end else if (c == 2) begin
        st2 = stall1;
      end else if (c == 3) begin
        d = rdata1; e = err1;
        rd1 = 1'b0; addr1 = '0; wdata1 = '0;
      end
    end
    $display("b2b ready_seen=%4b rdata=%08h err=%b", ready_seen, d, e);
    checks++;
    if (ready_seen !== 4'b0101) begin
      failures++; $display("FAIL b2b_ready: pattern=%4b, required 0101", ready_seen);
    end
    checks++;
    if (d !== 32'h0000_00A5 || e !== 1'b0) begin
      failures++; $display("FAIL b2b_read: data=%08h err=%b, required 000000a5/0", d, e);
    end
    checks++;
    if (st2 !== 1'b1) begin failures++; $display("FAIL b2b_stall: got %b, required 1", st2); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_hold();
    test_errors();
    test_both_high();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
